hamming_serial_tx: RTL

Serial Hamming(7,4) transmitter that sits directly upstream of the serial error-correcting receiver. It accepts a 4-bit nibble, encodes it into a 7-bit Hamming codeword, and can optionally flip one chosen bit to exercise the receiver's correction path. It then shifts the codeword out one bit at a time as a `d_out`/`strobe_out` pair. The receiver samples data on the rising edge of the strobe.

---
 rtl/hamming_serial_tx_if.sv | 25 ++
 rtl/hamming_serial_tx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hamming_serial_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hamming_serial_tx_if : request/serial-output bundle for the Hamming  |
// | serial transmitter.                    Revision 1.0                  |
// +----------------------------------------------------------------------+
interface hamming_serial_tx_if;
  logic       start;
  logic [3:0] d_in;
  logic [2:0] inj_pos;
  logic       d_out;
  logic       strobe_out;
  logic       busy;
  logic       done;

  modport master (
    output start, d_in, inj_pos,
    input  d_out, strobe_out, busy, done
  );

  modport slave (
    input  start, d_in, inj_pos,
    output d_out, strobe_out, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/hamming_serial_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hamming_serial_tx : Hamming(7,4) encoder with optional single-bit    |
// | error injection, shifted out as a d_out/strobe_out pair.  Rev 1.0    |
// +----------------------------------------------------------------------+
module hamming_serial_tx #(
  parameter int HALF = 4
) (
  input  wire                  clk,
  input  wire                  rst,
  hamming_serial_tx_if.slave   bus
);

  localparam int             PW      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0]  PH_LAST = PW'(HALF - 1);
  localparam logic [2:0]     IDX_LAST = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      cw_q, cw_d;
  logic [2:0]      idx_q, idx_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            d_out_q, d_out_d;
  logic            strobe_q, strobe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [6:0]      w_cw_new;
  logic [2:0]      w_idx_next;

  // Bit 0 of the codeword is position 1 (first on the wire).
  function automatic logic [6:0] encode(input logic [3:0] d, input logic [2:0] inj);
    logic d1, d2, d3, d4;
    logic [6:0] cw;
    d1 = d[3];
    d2 = d[2];
    d3 = d[1];
    d4 = d[0];
    cw = {d4, d3, d2, d2 ^ d3 ^ d4, d1, d1 ^ d3 ^ d4, d1 ^ d2 ^ d4};
    if (inj != 3'd0) begin
      cw[inj - 3'd1] = ~cw[inj - 3'd1];
    end
    return cw;
  endfunction

  assign w_cw_new   = encode(bus.d_in, bus.inj_pos);
  assign w_idx_next = idx_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    cw_d     = cw_q;
    idx_d    = idx_q;
    phase_d  = phase_q;
    d_out_d  = d_out_q;
    strobe_d = strobe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        d_out_d  = 1'b0;
        strobe_d = 1'b0;
        busy_d   = 1'b0;
        if (bus.start) begin
          cw_d    = w_cw_new;
          idx_d   = 3'd0;
          phase_d = '0;
          d_out_d = w_cw_new[0];
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (phase_q == PH_LAST) begin
          phase_d  = '0;
          strobe_d = 1'b1;
          state_d  = S_STROBE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      S_STROBE: begin
        if (phase_q == PH_LAST) begin
          phase_d  = '0;
          strobe_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            d_out_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Data only moves on the falling strobe edge.
            idx_d   = w_idx_next;
            d_out_d = cw_q[w_idx_next];
            state_d = S_SETUP;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      default: begin
        state_d  = S_IDLE;
        d_out_d  = 1'b0;
        strobe_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cw_q     <= '0;
      idx_q    <= '0;
      phase_q  <= '0;
      d_out_q  <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cw_q     <= cw_d;
      idx_q    <= idx_d;
      phase_q  <= phase_d;
      d_out_q  <= d_out_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.d_out      = d_out_q;
  assign bus.strobe_out = strobe_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
`default_nettype wire
